// File: rtl/game_speed_sched.sv
// Game-pace scheduler: tick pulse, score, level and hi_score (GAME_SPEED_SCHED_HISCORE_EN); no backpressure.
// All outputs registered; tick fires on the edge where div_cnt reaches period-1.
module game_speed_sched #(
  parameter int BASE_PERIOD     = 200000,
  parameter int STEP            = 10000,
  parameter int MAX_LEVEL       = 8,
  parameter int SCORE_DIV       = 4,
  parameter int SCORE_PER_LEVEL = 100,
  parameter int SCORE_MAX       = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  game_state,
  output logic        tick,
  output logic [13:0] score,
  output logic [3:0]  level,
  output logic        level_up,
  output logic [13:0] hi_score
);

  localparam int TW = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
  localparam int LW = (SCORE_PER_LEVEL > 1) ? $clog2(SCORE_PER_LEVEL) : 1;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_START = 2'd1,
    ST_END   = 2'd2,
    ST_RESET = 2'd3
  } state_t;

  state_t          gs;
  logic [19:0]     div_cnt;
  logic [TW-1:0]   tick_cnt;
  logic [LW-1:0]   lvl_cnt;
  logic [19:0]     period;
  logic            wrap;
  logic            tick_wrap;
  logic            score_inc;
  logic            lvl_wrap;

  assign gs     = state_t'(game_state);
  assign period = 20'(BASE_PERIOD) - 20'(level) * 20'(STEP);

  // >= rather than == so a shortened period never lets div_cnt run past it
  always_comb begin
    wrap      = (div_cnt >= (period - 20'd1));
    tick_wrap = (tick_cnt == TW'(SCORE_DIV - 1));
    score_inc = wrap && tick_wrap && (score < 14'(SCORE_MAX));
    lvl_wrap  = (lvl_cnt == LW'(SCORE_PER_LEVEL - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt  <= '0;
      tick_cnt <= '0;
      lvl_cnt  <= '0;
      score    <= '0;
      level    <= '0;
      tick     <= 1'b0;
      level_up <= 1'b0;
    end else begin
      tick     <= 1'b0;
      level_up <= 1'b0;
      case (gs)
        ST_START: begin
          if (wrap) begin
            div_cnt  <= '0;
            tick     <= 1'b1;
            tick_cnt <= tick_wrap ? '0 : tick_cnt + 1'b1;
            if (score_inc) begin
              score   <= score + 14'd1;
              lvl_cnt <= lvl_wrap ? '0 : lvl_cnt + 1'b1;
              if (lvl_wrap && (level < 4'(MAX_LEVEL))) begin
                level    <= level + 4'd1;
                level_up <= 1'b1;
              end
            end
          end else begin
            div_cnt <= div_cnt + 20'd1;
          end
        end
        ST_RESET: begin
          div_cnt  <= '0;
          tick_cnt <= '0;
          lvl_cnt  <= '0;
          score    <= '0;
          level    <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef GAME_SPEED_SCHED_HISCORE_EN
  logic end_q;

  // end_q marks that END was already seen, so only the first END cycle compares
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      end_q    <= 1'b0;
      hi_score <= '0;
    end else begin
      end_q <= (gs == ST_END);
      if ((gs == ST_END) && !end_q && (score > hi_score))
        hi_score <= score;
    end
  end
`else
  assign hi_score = '0;
`endif

endmodule
